// File: rtl/rf_pkg.sv
// Shared types and default widths for the scoreboarded register file.
// The FSM state enum is used by the top; the width defaults seed every module's parameters.
package rf_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_t;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/rf_busy_table.sv
// Per-register busy scoreboard: one bit per entry, set on issue, cleared on writeback,
// wiped wholesale on a full clear. Two lookup ports mirror the two read ports.
module rf_busy_table
  import rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              clr_all,
  input  logic [ADDR_W-1:0] look_a,
  input  logic [ADDR_W-1:0] look_b,
  output logic              busy_a,
  output logic              busy_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // Priority low to high: writeback clear, issue set (new producer), clear-all.
  always_comb begin
    busy_next = busy;
    if (clr_en) begin
      busy_next[clr_addr] = 1'b0;
    end
    if (set_en) begin
      busy_next[set_addr] = 1'b1;
    end
    if (clr_all) begin
      busy_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign busy_a = busy[look_a];
  assign busy_b = busy[look_b];

endmodule

// File: rtl/rf_param_scoreboard.sv
// Register file with two combinational read ports, one write port, optional zero register,
// optional write-through bypass, busy scoreboard and a one-entry-per-cycle clear engine.
module rf_param_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ClearReq,
  output logic              Ready,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueAddr,
  input  logic [ADDR_W-1:0] RsAddr,
  input  logic [ADDR_W-1:0] RtAddr,
  output logic [DATA_W-1:0] RsData,
  output logic [DATA_W-1:0] RtData,
  output logic              RsBusy,
  output logic              RtBusy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_t         state;
  rf_state_t         state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] regs [DEPTH];

  logic ready;
  logic clear_start;
  logic wr_ok;
  logic iss_ok;
  logic rs_zero;
  logic rt_zero;
  logic rs_hit;
  logic rt_hit;
  logic rs_busy_raw;
  logic rt_busy_raw;

  assign ready       = (state == ST_READY);
  assign clear_start = ready && ClearReq;
  assign wr_ok       = ready && RegWrite && !(ZERO_REG && (RdAddr == '0));
  assign iss_ok      = ready && IssueValid && !(ZERO_REG && (IssueAddr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: begin
        if (clr_cnt == LAST_IDX) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        if (ClearReq) begin
          state_next = ST_CLEAR;
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end else if (clear_start) begin
      clr_cnt <= '0;
    end
  end

  // The array has no reset of its own; the clear engine zeroes it and reads are masked until then.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      regs[clr_cnt] <= '0;
    end else if (wr_ok) begin
      regs[RdAddr] <= RdData;
    end
  end

  rf_busy_table #(
    .ADDR_W (ADDR_W)
  ) u_busy (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_ok),
    .set_addr (IssueAddr),
    .clr_en   (wr_ok),
    .clr_addr (RdAddr),
    .clr_all  (clear_start),
    .look_a   (RsAddr),
    .look_b   (RtAddr),
    .busy_a   (rs_busy_raw),
    .busy_b   (rt_busy_raw)
  );

  assign rs_zero = ZERO_REG && (RsAddr == '0);
  assign rt_zero = ZERO_REG && (RtAddr == '0);
  assign rs_hit  = BYPASS && wr_ok && (RdAddr == RsAddr);
  assign rt_hit  = BYPASS && wr_ok && (RdAddr == RtAddr);

  // A bypass hit means the producer is completing now, so the port is no longer busy.
  always_comb begin
    RsData = '0;
    RtData = '0;
    RsBusy = 1'b0;
    RtBusy = 1'b0;
    if (ready) begin
      if (!rs_zero) begin
        RsData = rs_hit ? RdData : regs[RsAddr];
        RsBusy = rs_busy_raw && !rs_hit;
      end
      if (!rt_zero) begin
        RtData = rt_hit ? RdData : regs[RtAddr];
        RtBusy = rt_busy_raw && !rt_hit;
      end
    end
  end

  assign Ready = ready;

endmodule

// File: tb/tb_rf_param_scoreboard.sv
// Directed bench for rf_param_scoreboard: one bypassing and one non-bypassing instance share stimulus.
module tb_rf_param_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        ClearReq;
  logic        RegWrite;
  logic [4:0]  RdAddr;
  logic [31:0] RdData;
  logic        IssueValid;
  logic [4:0]  IssueAddr;
  logic [4:0]  RsAddr;
  logic [4:0]  RtAddr;

  logic        ready, ready_nb;
  logic [31:0] rs_data, rt_data, rs_data_nb, rt_data_nb;
  logic        rs_busy, rt_busy, rs_busy_nb, rt_busy_nb;

  int n_checks = 0;
  int n_fail   = 0;
  int cycles;

  always #5 clk = ~clk;

  rf_param_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .ClearReq(ClearReq), .Ready(ready),
    .RegWrite(RegWrite), .RdAddr(RdAddr), .RdData(RdData),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr),
    .RsAddr(RsAddr), .RtAddr(RtAddr),
    .RsData(rs_data), .RtData(rt_data), .RsBusy(rs_busy), .RtBusy(rt_busy)
  );

  rf_param_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .ClearReq(ClearReq), .Ready(ready_nb),
    .RegWrite(RegWrite), .RdAddr(RdAddr), .RdData(RdData),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr),
    .RsAddr(RsAddr), .RtAddr(RtAddr),
    .RsData(rs_data_nb), .RtData(rt_data_nb), .RsBusy(rs_busy_nb), .RtBusy(rt_busy_nb)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e_rs;
    logic        e_rsb;
    logic [31:0] e_rt;
    logic        e_rtb;
    logic [31:0] n_rs;
    logic        n_rsb;
    logic [31:0] n_rt;
    logic        n_rtb;
  } vec_t;

  vec_t vecs [11];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ClearReq   = 1'b0;
    RegWrite   = 1'b0;
    RdAddr     = '0;
    RdData     = '0;
    IssueValid = 1'b0;
    IssueAddr  = '0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (ready && ready_nb) break;
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    RegWrite   = v.rw;
    RdAddr     = v.rd_addr;
    RdData     = v.rd_data;
    IssueValid = v.iv;
    IssueAddr  = v.ia;
    RsAddr     = v.rs;
    RtAddr     = v.rt;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  32'hF0F00F0F, 1'b0, 5'd0,  5'd5,  5'd0,
                 32'hF0F00F0F, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  5'd5,  5'd0,
                 32'hF0F00F0F, 1'b0, 32'h0, 1'b0, 32'hF0F00F0F, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  5'd0,  5'd0,
                 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd17, 5'd0,  5'd17,
                 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  5'd5,  5'd17,
                 32'hF0F00F0F, 1'b0, 32'h0, 1'b1, 32'hF0F00F0F, 1'b0, 32'h0, 1'b1};
    vecs[5]  = '{1'b1, 5'd17, 32'h12345678, 1'b0, 5'd0,  5'd5,  5'd17,
                 32'hF0F00F0F, 1'b0, 32'h12345678, 1'b0, 32'hF0F00F0F, 1'b0, 32'h0, 1'b1};
    vecs[6]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  5'd5,  5'd17,
                 32'hF0F00F0F, 1'b0, 32'h12345678, 1'b0, 32'hF0F00F0F, 1'b0, 32'h12345678, 1'b0};
    vecs[7]  = '{1'b1, 5'd17, 32'hCAFEBABE, 1'b1, 5'd17, 5'd5,  5'd17,
                 32'hF0F00F0F, 1'b0, 32'hCAFEBABE, 1'b0, 32'hF0F00F0F, 1'b0, 32'h12345678, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  5'd5,  5'd17,
                 32'hF0F00F0F, 1'b0, 32'hCAFEBABE, 1'b1, 32'hF0F00F0F, 1'b0, 32'hCAFEBABE, 1'b1};
    vecs[9]  = '{1'b1, 5'd3,  32'hAAAA5555, 1'b0, 5'd0,  5'd17, 5'd5,
                 32'hCAFEBABE, 1'b1, 32'hF0F00F0F, 1'b0, 32'hCAFEBABE, 1'b1, 32'hF0F00F0F, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  5'd3,  5'd17,
                 32'hAAAA5555, 1'b0, 32'hCAFEBABE, 1'b1, 32'hAAAA5555, 1'b0, 32'hCAFEBABE, 1'b1};

    // Reset and initial clear: Ready must rise exactly 32 edges after release.
    idle_inputs();
    RsAddr = 5'd5;
    RtAddr = 5'd31;
    rst = 1'b1;
    #1;
    check_output("reset_ready", {31'b0, ready}, 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_output("clear_rs_data", rs_data, 32'h0);
    check_output("clear_rt_busy", {31'b0, rt_busy}, 32'h0);
    RegWrite = 1'b1;
    RdAddr   = 5'd9;
    RdData   = 32'hDEADBEEF;
    wait_ready(cycles);
    idle_inputs();
    check_output("reset_clear_cycles", cycles + 1, 32);
    RsAddr = 5'd9;
    #1;
    check_output("post_reset_rs9", rs_data, 32'h0);
    check_output("post_reset_rt31", rt_data, 32'h0);
    check_output("post_reset_rs_busy", {31'b0, rs_busy}, 32'h0);
    check_output("post_reset_nb_rs9", rs_data_nb, 32'h0);

    // Table vectors: outputs are checked combinationally, then the edge commits the cycle.
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("v%0d_rs", i), rs_data, vecs[i].e_rs);
      check_output($sformatf("v%0d_rs_busy", i), {31'b0, rs_busy}, {31'b0, vecs[i].e_rsb});
      check_output($sformatf("v%0d_rt", i), rt_data, vecs[i].e_rt);
      check_output($sformatf("v%0d_rt_busy", i), {31'b0, rt_busy}, {31'b0, vecs[i].e_rtb});
      check_output($sformatf("v%0d_nb_rs", i), rs_data_nb, vecs[i].n_rs);
      check_output($sformatf("v%0d_nb_rs_busy", i), {31'b0, rs_busy_nb}, {31'b0, vecs[i].n_rsb});
      check_output($sformatf("v%0d_nb_rt", i), rt_data_nb, vecs[i].n_rt);
      check_output($sformatf("v%0d_nb_rt_busy", i), {31'b0, rt_busy_nb}, {31'b0, vecs[i].n_rtb});
      tick();
    end
    idle_inputs();

    // Requested clear: writes and issues during it are dropped, busy is wiped.
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    check_output("clearreq_ready", {31'b0, ready}, 32'h0);
    RsAddr = 5'd3;
    RtAddr = 5'd17;
    #1;
    check_output("clearreq_rs", rs_data, 32'h0);
    check_output("clearreq_rt_busy", {31'b0, rt_busy}, 32'h0);
    RegWrite   = 1'b1;
    RdAddr     = 5'd3;
    RdData     = 32'hDEADBEEF;
    IssueValid = 1'b1;
    IssueAddr  = 5'd9;
    wait_ready(cycles);
    idle_inputs();
    check_output("clearreq_cycles", cycles, 32);
    RsAddr = 5'd3;
    RtAddr = 5'd17;
    #1;
    check_output("after_clear_r3", rs_data, 32'h0);
    check_output("after_clear_r17", rt_data, 32'h0);
    check_output("after_clear_rt17_busy", {31'b0, rt_busy}, 32'h0);
    check_output("after_clear_nb_r17_busy", {31'b0, rt_busy_nb}, 32'h0);
    RsAddr = 5'd9;
    #1;
    check_output("after_clear_rs9_busy", {31'b0, rs_busy}, 32'h0);

    // Reset in the middle of a clear restarts the engine from entry 0.
    RegWrite = 1'b1;
    RdAddr   = 5'd4;
    RdData   = 32'h11111111;
    tick();
    idle_inputs();
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check_output("midclear_reset_ready", {31'b0, ready}, 32'h0);
    tick();
    rst = 1'b0;
    wait_ready(cycles);
    check_output("midclear_restart_cycles", cycles, 32);
    RsAddr = 5'd4;
    #1;
    check_output("midclear_r4", rs_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
